// File: rtl/out_pkg.sv
// Shared types and helpers for the out_block_tx block-print device.
// OUT_EOR_EN adds the StEor state used to append an end-of-record frame.
package out_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend
`ifdef OUT_EOR_EN
        , StEor
`endif
    } state_e;

    localparam int unsigned DEF_WORD_W = 30;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/out_block_tx_if.sv
// CPU/memory-side bus of out_block_tx: start request, memory read port and status.
interface out_block_tx_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WORD_W = out_pkg::DEF_WORD_W
);
    logic              start;
    logic [ADDR_W-1:0] addressin;
    logic [WORD_W-1:0] in;
    logic [ADDR_W-1:0] addressout;
    logic              load;
    logic              stop;
    logic              busy;

    modport master (
        output start, addressin, in,
        input  addressout, load, stop, busy
    );

    modport slave (
        input  start, addressin, in,
        output addressout, load, stop, busy
    );
endinterface

// File: rtl/out_uart_tx.sv
// Async serial transmitter: start bit, BYTE_W data bits LSB-first, one stop bit.
module out_uart_tx #(
    parameter int unsigned BYTE_W       = 6,
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BYTE_W-1:0] in,
    input  logic              load,
    output logic              ready,
    output logic              tx
);
    localparam int unsigned FrameBits = BYTE_W + 2;
    localparam int unsigned BitW      = $clog2(FrameBits + 1);
    localparam int unsigned TimW      = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);

    logic                 active_q;
    logic [FrameBits-1:0] shift_q;
    logic [BitW-1:0]      bits_q;
    logic [TimW-1:0]      timer_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bits_q   <= '0;
            timer_q  <= '0;
        end else if (!active_q) begin
            if (load) begin
                active_q <= 1'b1;
                shift_q  <= {1'b1, in, 1'b0};
                bits_q   <= BitW'(FrameBits);
                timer_q  <= TimW'(CLKS_PER_BIT - 1);
            end
        end else if (timer_q == '0) begin
            shift_q <= {1'b1, shift_q[FrameBits-1:1]};
            bits_q  <= bits_q - BitW'(1);
            timer_q <= TimW'(CLKS_PER_BIT - 1);
            if (bits_q == BitW'(1)) active_q <= 1'b0;
        end else begin
            timer_q <= timer_q - TimW'(1);
        end
    end

    always_comb begin
        ready = !active_q;
        tx    = active_q ? shift_q[0] : 1'b1;
    end

endmodule

// File: rtl/out_block_tx.sv
// Block OUT device: fetches WORDS memory words on start, then serialises every byte over tx.
// Define OUT_EOR_EN to append one EOR_CODE frame after each block.
module out_block_tx
    import out_pkg::*;
#(
    parameter int unsigned       WORDS        = 3,
    parameter int unsigned       BYTES        = 5,
    parameter int unsigned       BYTE_W       = 6,
    parameter int unsigned       ADDR_W       = 12,
    parameter int unsigned       CLKS_PER_BIT = 104,
    parameter logic [BYTE_W-1:0] EOR_CODE     = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    out_block_tx_if.slave  bus,
    output logic           tx
);
    localparam int unsigned WORD_W = BYTES * BYTE_W;
    localparam int unsigned WidxW  = idx_w(WORDS + 1);
    localparam int unsigned WselW  = idx_w(WORDS);
    localparam int unsigned BidxW  = idx_w(BYTES);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   buf_q [WORDS];
    logic [WidxW-1:0]    widx_q;
    logic [BidxW-1:0]    bidx_q;
    logic                done_q;

    logic                uart_ready, uart_load;
    logic                accept, fin, last_word, last_byte, eor_sel, sending;
    logic [WORD_W-1:0]   word_sel;
    logic [BYTE_W-1:0]   byte_sel, uart_data;

    always_comb begin
        last_word = widx_q == WidxW'(WORDS - 1);
        last_byte = bidx_q == BidxW'(BYTES - 1);
        sending   = (state_q != StIdle) && (state_q != StFetch);
        // The final frame finishing frees the device in the same cycle, so a start there is taken.
        fin       = sending && done_q && uart_ready;
        accept    = bus.start && ((state_q == StIdle) || fin);
        word_sel  = buf_q[WselW'(widx_q)];
        byte_sel  = BYTE_W'(word_sel >> (BYTE_W * (BYTES - 1 - 32'(bidx_q))));
`ifdef OUT_EOR_EN
        eor_sel   = state_q == StEor;
`else
        eor_sel   = 1'b0;
`endif
        uart_data      = eor_sel ? EOR_CODE : byte_sel;
        uart_load      = sending && uart_ready && !done_q;
        bus.load       = accept || ((state_q == StFetch) && !last_word);
        bus.addressout = accept ? bus.addressin : addr_q;
        bus.stop       = (state_q == StFetch) && last_word;
        bus.busy       = accept || ((state_q != StIdle) && !fin);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < WORDS; k++) buf_q[k] <= '0;
        end else if (accept) begin
            state_q <= StFetch;
            addr_q  <= bus.addressin + ADDR_W'(1);
            widx_q  <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    // widx_q counts captured words here; the read for word widx_q+1 is in flight.
                    buf_q[WselW'(widx_q)] <= bus.in;
                    if (last_word) begin
                        state_q <= StSend;
                        widx_q  <= '0;
                        bidx_q  <= '0;
                        done_q  <= 1'b0;
                    end else begin
                        widx_q <= widx_q + WidxW'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                StSend: begin
                    if (fin) begin
                        state_q <= StIdle;
                    end else if (uart_load) begin
                        if (last_byte) begin
                            bidx_q <= '0;
                            if (last_word) begin
`ifdef OUT_EOR_EN
                                state_q <= StEor;
`else
                                done_q  <= 1'b1;
`endif
                            end else begin
                                widx_q <= widx_q + WidxW'(1);
                            end
                        end else begin
                            bidx_q <= bidx_q + BidxW'(1);
                        end
                    end
                end
`ifdef OUT_EOR_EN
                StEor: begin
                    if (fin) state_q <= StIdle;
                    else if (uart_load) done_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    out_uart_tx #(
        .BYTE_W       (BYTE_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (uart_data),
        .load    (uart_load),
        .ready   (uart_ready),
        .tx      (tx)
    );

endmodule

// File: tb/tb_out_block_tx.sv
// Bench for out_block_tx: default geometry (dut_a) and a 1-word/2-byte/8-bit geometry (dut_b).
module tb_out_block_tx;
    localparam int unsigned Cpb = 4;
    localparam int unsigned Aw  = 12;
    localparam int unsigned Wa = 3, Ba = 5, Bwa = 6, Wwa = 30;
    localparam int unsigned Wb = 1, Bb = 2, Bwb = 8, Wwb = 16;
`ifdef OUT_EOR_EN
    localparam int unsigned EorN = 1;
`else
    localparam int unsigned EorN = 0;
`endif
    localparam logic [5:0] EorA = 6'o77;
    localparam logic [7:0] EorB = 8'h00;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    out_block_tx_if #(.ADDR_W(Aw), .WORD_W(Wwa)) bus_a ();
    out_block_tx_if #(.ADDR_W(Aw), .WORD_W(Wwb)) bus_b ();
    logic tx_a, tx_b;

    out_block_tx #(.WORDS(Wa), .BYTES(Ba), .BYTE_W(Bwa), .ADDR_W(Aw), .CLKS_PER_BIT(Cpb),
                   .EOR_CODE(EorA)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .tx(tx_a));
    out_block_tx #(.WORDS(Wb), .BYTES(Bb), .BYTE_W(Bwb), .ADDR_W(Aw), .CLKS_PER_BIT(Cpb),
                   .EOR_CODE(EorB)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b), .tx(tx_b));

    logic [Wwa-1:0] mem_a [4096];
    logic [Wwb-1:0] mem_b [4096];
    logic [7:0]     exp_byte_a [$];
    logic [7:0]     exp_byte_b [$];
    logic [11:0]    exp_addr_a [$];
    logic [11:0]    exp_addr_b [$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, rst_cnt = 0;
    int frames_a = 0, frames_b = 0, loads_a = 0, loads_b = 0, stops_a = 0, stops_b = 0;
    int stop_cyc_a = 0, stop_cyc_b = 0, start_cyc_a = 0, start_cyc_b = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.load) bus_a.in <= mem_a[bus_a.addressout];
        if (bus_b.load) bus_b.in <= mem_b[bus_b.addressout];
    end

    // Memory-port monitors: every load must match the next expected address.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_a.load) begin
                loads_a <= loads_a + 1;
                if (exp_addr_a.size() == 0) check_eq("unexpected_load_a", 32'(bus_a.addressout), 32'hDEAD);
                else check_eq("addr_a", 32'(bus_a.addressout), 32'(exp_addr_a.pop_front()));
            end
            if (bus_a.stop) begin stops_a <= stops_a + 1; stop_cyc_a <= cyc; end
            if (bus_b.load) begin
                loads_b <= loads_b + 1;
                if (exp_addr_b.size() == 0) check_eq("unexpected_load_b", 32'(bus_b.addressout), 32'hDEAD);
                else check_eq("addr_b", 32'(bus_b.addressout), 32'(exp_addr_b.pop_front()));
            end
            if (bus_b.stop) begin stops_b <= stops_b + 1; stop_cyc_b <= cyc; end
        end
    end

    // Called on the first negedge of a start bit; samples each bit near its middle.
    task automatic rx_frame(input bit sel_b, input int bw, output logic [7:0] v, output logic sb);
        v = '0;
        repeat (Cpb / 2) @(negedge clk);
        for (int i = 0; i < bw; i++) begin
            repeat (Cpb) @(negedge clk);
            v[i] = sel_b ? tx_b : tx_a;
        end
        repeat (Cpb) @(negedge clk);
        sb = sel_b ? tx_b : tx_a;
    endtask

    initial begin : mon_a
        logic [7:0] v;
        logic sb;
        int r0;
        forever begin
            @(negedge clk);
            if (reset_n && tx_a === 1'b0) begin
                r0 = rst_cnt;
                rx_frame(1'b0, Bwa, v, sb);
                if (r0 == rst_cnt) begin
                    frames_a++;
                    check_eq("stop_bit_a", 32'(sb), 32'd1);
                    if (exp_byte_a.size() == 0) check_eq("extra_frame_a", 32'(v), 32'hDEAD);
                    else check_eq("frame_a", 32'(v), 32'(exp_byte_a.pop_front()));
                end
            end
        end
    end

    initial begin : mon_b
        logic [7:0] v;
        logic sb;
        int r0;
        forever begin
            @(negedge clk);
            if (reset_n && tx_b === 1'b0) begin
                r0 = rst_cnt;
                rx_frame(1'b1, Bwb, v, sb);
                if (r0 == rst_cnt) begin
                    frames_b++;
                    check_eq("stop_bit_b", 32'(sb), 32'd1);
                    if (exp_byte_b.size() == 0) check_eq("extra_frame_b", 32'(v), 32'hDEAD);
                    else check_eq("frame_b", 32'(v), 32'(exp_byte_b.pop_front()));
                end
            end
        end
    end

    task automatic run_a(input logic [11:0] addr);
        @(posedge clk); #1;
        bus_a.start = 1'b1;
        bus_a.addressin = addr;
        start_cyc_a = cyc;
        for (int k = 0; k < Wa; k++) begin
            logic [11:0] a;
            logic [Wwa-1:0] w;
            a = addr + 12'(k);
            w = mem_a[a];
            exp_addr_a.push_back(a);
            for (int j = 0; j < Ba; j++) exp_byte_a.push_back(8'(w >> (Bwa * (Ba - 1 - j))) & 8'h3F);
        end
        if (EorN != 0) exp_byte_a.push_back(8'(EorA));
        #3;
        check_eq("start_busy_a", 32'(bus_a.busy), 32'd1);
        check_eq("start_load_a", 32'(bus_a.load), 32'd1);
        @(posedge clk); #1;
        bus_a.start = 1'b0;
    endtask

    task automatic run_b(input logic [11:0] addr);
        @(posedge clk); #1;
        bus_b.start = 1'b1;
        bus_b.addressin = addr;
        start_cyc_b = cyc;
        exp_addr_b.push_back(addr);
        exp_byte_b.push_back(mem_b[addr][15:8]);
        exp_byte_b.push_back(mem_b[addr][7:0]);
        if (EorN != 0) exp_byte_b.push_back(EorB);
        @(posedge clk); #1;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sel_b ? bus_b.busy : bus_a.busy) && n < 3000);
        check_eq(sel_b ? "idle_b" : "idle_a", 32'(sel_b ? bus_b.busy : bus_a.busy), 32'd0);
    endtask

    task automatic wait_frames_a(input int target);
        int n;
        n = 0;
        while (frames_a < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("frames_wait_a", 32'(frames_a >= target), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int f0, l0, s0;
        logic [11:0] held;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = Wwa'($urandom);
            mem_b[i] = Wwb'($urandom);
        end
        mem_a[100] = 30'o0102030405;
        mem_a[101] = 30'o0607101112;
        mem_a[102] = 30'o1314151617;
        bus_a.start = 1'b0; bus_a.addressin = '0;
        bus_b.start = 1'b0; bus_b.addressin = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_load", 32'(bus_a.load), 32'd0);
        check_eq("rst_stop", 32'(bus_a.stop), 32'd0);
        check_eq("rst_busy", 32'(bus_a.busy), 32'd0);
        check_eq("rst_tx", 32'(tx_a), 32'd1);
        check_eq("rst_addr", 32'(bus_a.addressout), 32'd0);
        check_eq("rst_tx_b", 32'(tx_b), 32'd1);
        reset_n = 1'b1;

        // Basic block at 100: frames 01..17 octal in order.
        f0 = frames_a; l0 = loads_a; s0 = stops_a;
        run_a(12'd100);
        wait_idle(1'b0);
        check_eq("t1_frames", 32'(frames_a - f0), 32'(Wa * Ba + EorN));
        check_eq("t1_loads", 32'(loads_a - l0), 32'(Wa));
        check_eq("t1_stops", 32'(stops_a - s0), 32'd1);
        check_eq("t1_stop_cycle", 32'(stop_cyc_a - start_cyc_a), 32'(Wa));
        check_eq("t1_left", 32'(exp_byte_a.size()), 32'd0);

        // Address wrap.
        f0 = frames_a;
        run_a(12'd4094);
        wait_idle(1'b0);
        check_eq("t2_frames", 32'(frames_a - f0), 32'(Wa * Ba + EorN));
        check_eq("t2_addr_left", 32'(exp_addr_a.size()), 32'd0);

        // Start while busy is ignored.
        f0 = frames_a; l0 = loads_a; s0 = stops_a;
        run_a(12'd200);
        wait_frames_a(f0 + 3);
        @(posedge clk); #1;
        held = bus_a.addressout;
        bus_a.start = 1'b1;
        bus_a.addressin = 12'd500;
        #3;
        check_eq("t3_no_load", 32'(bus_a.load), 32'd0);
        check_eq("t3_addr_held", 32'(bus_a.addressout), 32'(held));
        check_eq("t3_busy", 32'(bus_a.busy), 32'd1);
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        wait_idle(1'b0);
        check_eq("t3_frames", 32'(frames_a - f0), 32'(Wa * Ba + EorN));
        check_eq("t3_loads", 32'(loads_a - l0), 32'(Wa));
        check_eq("t3_stops", 32'(stops_a - s0), 32'd1);

        // Reset in the middle of the 7th frame, then a normal block.
        f0 = frames_a;
        run_a(12'd300);
        wait_frames_a(f0 + 6);
        repeat (3 * Cpb) @(posedge clk);
        #2;
        reset_n = 1'b0;
        rst_cnt++;
        #1;
        check_eq("t4_tx", 32'(tx_a), 32'd1);
        check_eq("t4_busy", 32'(bus_a.busy), 32'd0);
        check_eq("t4_load", 32'(bus_a.load), 32'd0);
        check_eq("t4_addr", 32'(bus_a.addressout), 32'd0);
        exp_byte_a.delete();
        exp_addr_a.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (50) @(posedge clk);
        f0 = frames_a;
        run_a(12'd100);
        wait_idle(1'b0);
        check_eq("t4_frames", 32'(frames_a - f0), 32'(Wa * Ba + EorN));
        check_eq("t4_left", 32'(exp_byte_a.size()), 32'd0);

        // Narrow geometry: one word of two 8-bit bytes.
        f0 = frames_b; l0 = loads_b; s0 = stops_b;
        run_b(12'h0F0);
        wait_idle(1'b1);
        check_eq("t6_frames", 32'(frames_b - f0), 32'(2 + EorN));
        check_eq("t6_loads", 32'(loads_b - l0), 32'd1);
        check_eq("t6_stops", 32'(stops_b - s0), 32'd1);
        check_eq("t6_stop_cycle", 32'(stop_cyc_b - start_cyc_b), 32'd1);
        check_eq("t6_left", 32'(exp_byte_b.size()), 32'd0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
